// File: rtl/mem_access_if.sv
// Data-memory port of the memory-access stage: a single outstanding
// request held until the memory answers with a one-cycle ack.
interface mem_access_if #(
   parameter int B = 32
) ();
   logic         req;    // request outstanding
   logic         we;     // 1 = write
   logic [B-1:0] addr;   // word address, low two bits always zero
   logic [B-1:0] wdata;  // lane-replicated store data
   logic [3:0]   be;     // byte enables
   logic [B-1:0] rdata;  // read data, valid with ack
   logic         ack;    // transaction complete

   modport master (
      output req, we, addr, wdata, be,
      input  rdata, ack
   );

   modport slave (
      input  req, we, addr, wdata, be,
      output rdata, ack
   );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage (between execute and write-back).
// Issues one data-memory transaction per load/store over a req/ack port,
// stalls execute while it is outstanding, aligns and extends load data and
// registers the MEM/WB fields used by the write-back mux.
// Optional build macro MEM_MISALIGN_TRAP_EN: adds the misalign output and
// turns misaligned half/word accesses into single-cycle, no-write bubbles
// instead of silently ignoring the low address bits.
module mem_access #(
   parameter int B = 32,   // data/address width, four byte lanes only
   parameter int D = 5     // register-index width
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ex_valid,
   input  logic [B-1:0] ex_ALU_data,
   input  logic [B-1:0] ex_store_data,
   input  logic [D-1:0] ex_write_reg,
   input  logic         ex_MemRead,
   input  logic         ex_MemWrite,
   input  logic         ex_MemtoReg,
   input  logic         ex_RegWrite,
   input  logic [1:0]   ex_size,
   input  logic         ex_unsigned,
   output logic         stall_out,
   mem_access_if.master dmem,
   output logic         wb_valid,
   output logic [B-1:0] wb_mem_data,
   output logic [B-1:0] wb_ALU_data,
   output logic         wb_MemtoReg,
   output logic         wb_RegWrite,
`ifdef MEM_MISALIGN_TRAP_EN
   output logic         misalign,
`endif
   output logic [D-1:0] wb_write_reg
);

   typedef enum logic {IDLE, ACCESS} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   state_t       state_q, state_d;
   logic         mem_op;
   logic         trap;
   logic         start;      // IDLE -> ACCESS this edge
   logic         finish;     // ack accepted this edge
   logic         direct;     // non-memory (or trapped) op captured this edge
   logic         stall_c;
   logic [3:0]   be_c;
   logic [B-1:0] wdata_c;

   // Transaction context latched at issue for aligning the returned data.
   logic [1:0]   lane_q;
   logic [1:0]   size_q;
   logic         uns_q;
   logic [7:0]   byte_sel;
   logic [15:0]  half_sel;
   logic [B-1:0] load_c;

   logic         wb_regwrite_q;

   assign mem_op = ex_MemRead | ex_MemWrite;

`ifdef MEM_MISALIGN_TRAP_EN
   assign trap = mem_op &
                 (((ex_size == SZ_HALF) & ex_ALU_data[0]) |
                  (ex_size[1] & (|ex_ALU_data[1:0])));
`else
   assign trap = 1'b0;
`endif

   // State register; an async reset abandons any outstanding request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state, stall and transaction strobes.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d = state_q;
      stall_c = 1'b0;
      start   = 1'b0;
      finish  = 1'b0;
      direct  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ex_valid && mem_op && !trap) begin
               stall_c = 1'b1;
               start   = 1'b1;
               state_d = ACCESS;
            end else if (ex_valid) begin
               direct  = 1'b1;
            end
         end
         ACCESS: begin
            if (dmem.ack) begin
               finish  = 1'b1;
               state_d = IDLE;
            end else begin
               stall_c = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stall is forced low while reset is held so execute is not frozen by it.
   assign stall_out = stall_c & rst_n;
   assign dmem.req  = (state_q == ACCESS);

   // Store lane steering: replicate the datum so every lane sees it.
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = ex_store_data;
      case (ex_size)
         SZ_BYTE: begin
            be_c    = 4'b0001 << ex_ALU_data[1:0];
            wdata_c = {4{ex_store_data[7:0]}};
         end
         SZ_HALF: begin
            be_c    = ex_ALU_data[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{ex_store_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Bus outputs and alignment context, captured at issue and held through ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: only control/datapath flops here, no arrays, so every one is reset to a known zero.
      if (!rst_n) begin
         dmem.we    <= 1'b0;
         dmem.addr  <= '0;
         dmem.wdata <= '0;
         dmem.be    <= '0;
         lane_q     <= '0;
         size_q     <= '0;
         uns_q      <= 1'b0;
      end else if (start) begin
         // NOTE: non-blocking assignments here so all flops sample pre-edge values together.
         dmem.we    <= ex_MemWrite;
         dmem.addr  <= {ex_ALU_data[B-1:2], 2'b00};
         dmem.wdata <= wdata_c;
         dmem.be    <= be_c;
         lane_q     <= ex_ALU_data[1:0];
         size_q     <= ex_size;
         uns_q      <= ex_unsigned;
      end
   end

   // Load alignment and sign/zero extension of the returned word.
   always_comb begin
      byte_sel = dmem.rdata[{lane_q, 3'b000} +: 8];
      half_sel = dmem.rdata[{lane_q[1], 4'b0000} +: 16];
      case (size_q)
         SZ_BYTE: load_c = {{(B-8){~uns_q & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_c = {{(B-16){~uns_q & half_sel[15]}}, half_sel};
         default: load_c = dmem.rdata;
      endcase
   end

   // MEM/WB register: written on a direct op or on the accepted ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid      <= 1'b0;
         wb_mem_data   <= '0;
         wb_ALU_data   <= '0;
         wb_MemtoReg   <= 1'b0;
         wb_regwrite_q <= 1'b0;
         wb_write_reg  <= '0;
      end else begin
         wb_valid <= direct | finish;
         if (direct || finish) begin
            wb_mem_data   <= (finish && !dmem.we) ? load_c : '0;
            wb_ALU_data   <= ex_ALU_data;
            wb_MemtoReg   <= ex_MemtoReg;
            wb_regwrite_q <= ex_RegWrite & ~trap;
            wb_write_reg  <= ex_write_reg;
         end
      end
   end

   assign wb_RegWrite = wb_regwrite_q & wb_valid;

`ifdef MEM_MISALIGN_TRAP_EN
   // Misalign flag pulses alongside the bubble it explains.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) misalign <= 1'b0;
      else        misalign <= direct & trap;
   end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: drives execute-side vectors, plays the
// memory side with scripted ack delays and compares against hand-computed
// values.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [31:0] ex_ALU_data;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_write_reg;
   logic        ex_MemRead;
   logic        ex_MemWrite;
   logic        ex_MemtoReg;
   logic        ex_RegWrite;
   logic [1:0]  ex_size;
   logic        ex_unsigned;
   logic        stall_out;
   logic        wb_valid;
   logic [31:0] wb_mem_data;
   logic [31:0] wb_ALU_data;
   logic        wb_MemtoReg;
   logic        wb_RegWrite;
   logic [4:0]  wb_write_reg;
`ifdef MEM_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   mem_access_if #(.B(32)) dmem_if ();

   mem_access #(.B(32), .D(5)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid      (ex_valid),
      .ex_ALU_data   (ex_ALU_data),
      .ex_store_data (ex_store_data),
      .ex_write_reg  (ex_write_reg),
      .ex_MemRead    (ex_MemRead),
      .ex_MemWrite   (ex_MemWrite),
      .ex_MemtoReg   (ex_MemtoReg),
      .ex_RegWrite   (ex_RegWrite),
      .ex_size       (ex_size),
      .ex_unsigned   (ex_unsigned),
      .stall_out     (stall_out),
      .dmem          (dmem_if.master),
      .wb_valid      (wb_valid),
      .wb_mem_data   (wb_mem_data),
      .wb_ALU_data   (wb_ALU_data),
      .wb_MemtoReg   (wb_MemtoReg),
      .wb_RegWrite   (wb_RegWrite),
`ifdef MEM_MISALIGN_TRAP_EN
      .misalign      (misalign),
`endif
      .wb_write_reg  (wb_write_reg)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int stalls;

   // Bus values seen in the first ACCESS cycle of the last transaction.
   logic        seen_req;
   logic        seen_we;
   logic [31:0] seen_addr;
   logic [31:0] seen_wdata;
   logic [3:0]  seen_be;
   logic        seen_wbv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] st,
                         input logic [4:0] rd, input logic mr, input logic mw,
                         input logic m2r, input logic rw, input logic [1:0] sz,
                         input logic uns);
      ex_valid      = v;
      ex_ALU_data   = alu;
      ex_store_data = st;
      ex_write_reg  = rd;
      ex_MemRead    = mr;
      ex_MemWrite   = mw;
      ex_MemtoReg   = m2r;
      ex_RegWrite   = rw;
      ex_size       = sz;
      ex_unsigned   = uns;
   endtask

   // Runs one memory op already presented on ex_*: `waits` ACCESS cycles
   // without ack, then an ack carrying rdata. Returns with the wb_* result
   // visible and counts the cycles stall_out was high.
   task automatic run_mem(input int waits, input logic [31:0] rdata, output int n_stall);
      n_stall = 0;
      #1;
      if (stall_out) n_stall++;
      tick();
      seen_req   = dmem_if.req;
      seen_we    = dmem_if.we;
      seen_addr  = dmem_if.addr;
      seen_wdata = dmem_if.wdata;
      seen_be    = dmem_if.be;
      seen_wbv   = wb_valid;
      for (int i = 0; i < waits; i++) begin
         if (stall_out) n_stall++;
         tick();
      end
      dmem_if.ack   = 1'b1;
      dmem_if.rdata = rdata;
      #1;
      if (stall_out) n_stall++;
      @(posedge clk);
      #1;
      dmem_if.ack   = 1'b0;
      dmem_if.rdata = '0;
   endtask

   initial begin
      rst_n         = 1'b0;
      dmem_if.ack   = 1'b0;
      dmem_if.rdata = '0;
      set_ex(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 2'b00, 0);
      #2;
      check("reset_stall", {31'd0, stall_out}, 32'd0);
      check("reset_req", {31'd0, dmem_if.req}, 32'd0);
      check("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("reset_wb_alu", wb_ALU_data, 32'h0);
      check("reset_wb_regwrite", {31'd0, wb_RegWrite}, 32'd0);
      check("reset_addr", dmem_if.addr, 32'h0);
      tick();
      rst_n = 1'b1;

      // Non-memory op: one-cycle latency, no stall.
      set_ex(1, 32'h0000_1234, 32'h0, 5'd7, 0, 0, 0, 1, 2'b10, 0);
      #1;
      check("alu_stall", {31'd0, stall_out}, 32'd0);
      tick();
      check("alu_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("alu_wb_alu", wb_ALU_data, 32'h0000_1234);
      check("alu_wb_rd", {27'd0, wb_write_reg}, 32'd7);
      check("alu_wb_regwrite", {31'd0, wb_RegWrite}, 32'd1);
      check("alu_wb_mem", wb_mem_data, 32'h0);

      // Idle cycle with a stray ack: bubble, other fields hold.
      ex_valid    = 1'b0;
      dmem_if.ack = 1'b1;
      tick();
      dmem_if.ack = 1'b0;
      check("idle_wb_valid", {31'd0, wb_valid}, 32'd0);
      check("idle_regwrite_gated", {31'd0, wb_RegWrite}, 32'd0);
      check("idle_alu_hold", wb_ALU_data, 32'h0000_1234);
      check("idle_ack_no_req", {31'd0, dmem_if.req}, 32'd0);

      // LB 0x103, three wait cycles.
      set_ex(1, 32'h0000_0103, 32'h0, 5'd3, 1, 0, 1, 1, 2'b00, 0);
      run_mem(3, 32'h80AA_BBCC, stalls);
      check("lb_stall_cycles", stalls, 32'd4);
      check("lb_req", {31'd0, seen_req}, 32'd1);
      check("lb_addr", seen_addr, 32'h0000_0100);
      check("lb_we", {31'd0, seen_we}, 32'd0);
      check("lb_bubble", {31'd0, seen_wbv}, 32'd0);
      check("lb_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("lb_data", wb_mem_data, 32'hFFFF_FF80);
      check("lb_memtoreg", {31'd0, wb_MemtoReg}, 32'd1);
      check("lb_rd", {27'd0, wb_write_reg}, 32'd3);
      check("lb_req_drop", {31'd0, dmem_if.req}, 32'd0);

      // LBU same access.
      set_ex(1, 32'h0000_0103, 32'h0, 5'd3, 1, 0, 1, 1, 2'b00, 1);
      run_mem(3, 32'h80AA_BBCC, stalls);
      check("lbu_data", wb_mem_data, 32'h0000_0080);

      // LH upper half, signed.
      set_ex(1, 32'h0000_0102, 32'h0, 5'd4, 1, 0, 1, 1, 2'b01, 0);
      run_mem(1, 32'h8001_7FFF, stalls);
      check("lh_data", wb_mem_data, 32'hFFFF_8001);

      // LHU lower half.
      set_ex(1, 32'h0000_0100, 32'h0, 5'd4, 1, 0, 1, 1, 2'b01, 1);
      run_mem(0, 32'h1234_F00D, stalls);
      check("lhu_data", wb_mem_data, 32'h0000_F00D);

      // SH 0x202, same-cycle ack.
      set_ex(1, 32'h0000_0202, 32'h1234_ABCD, 5'd0, 0, 1, 0, 0, 2'b01, 0);
      run_mem(0, 32'hFFFF_FFFF, stalls);
      check("sh_stall_cycles", stalls, 32'd1);
      check("sh_we", {31'd0, seen_we}, 32'd1);
      check("sh_be", {28'd0, seen_be}, 32'h0000_000C);
      check("sh_wdata", seen_wdata, 32'hABCD_ABCD);
      check("sh_addr", seen_addr, 32'h0000_0200);
      check("sh_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("sh_regwrite", {31'd0, wb_RegWrite}, 32'd0);
      check("sh_mem_data", wb_mem_data, 32'h0);

      // SB with MemRead also set: still a store, RegWrite passed through.
      set_ex(1, 32'h0000_0301, 32'h0000_00EF, 5'd6, 1, 1, 0, 1, 2'b00, 0);
      run_mem(0, 32'h5555_5555, stalls);
      check("sb_we", {31'd0, seen_we}, 32'd1);
      check("sb_be", {28'd0, seen_be}, 32'h0000_0002);
      check("sb_wdata", seen_wdata, 32'hEFEF_EFEF);
      check("sb_regwrite", {31'd0, wb_RegWrite}, 32'd1);
      check("sb_mem_data", wb_mem_data, 32'h0);

      // SW: full word, all lanes.
      set_ex(1, 32'h0000_0408, 32'hCAFE_1234, 5'd0, 0, 1, 0, 0, 2'b11, 0);
      run_mem(2, 32'h0, stalls);
      check("sw_be", {28'd0, seen_be}, 32'h0000_000F);
      check("sw_wdata", seen_wdata, 32'hCAFE_1234);
      check("sw_stall_cycles", stalls, 32'd3);

      // LW followed immediately by ADD.
      set_ex(1, 32'h0000_0400, 32'h0, 5'd10, 1, 0, 1, 1, 2'b10, 0);
      run_mem(1, 32'hDEAD_BEEF, stalls);
      check("lw_stall_cycles", stalls, 32'd2);
      check("lw_data", wb_mem_data, 32'hDEAD_BEEF);
      check("lw_rd", {27'd0, wb_write_reg}, 32'd10);
      set_ex(1, 32'h0000_0055, 32'h0, 5'd9, 0, 0, 0, 1, 2'b10, 0);
      #1;
      check("add_no_stall", {31'd0, stall_out}, 32'd0);
      tick();
      check("add_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("add_wb_alu", wb_ALU_data, 32'h0000_0055);
      check("add_wb_rd", {27'd0, wb_write_reg}, 32'd9);
      check("add_memtoreg", {31'd0, wb_MemtoReg}, 32'd0);
      ex_valid = 1'b0;
      tick();
      check("add_no_dup", {31'd0, wb_valid}, 32'd0);

      // LW at misaligned 0x101.
      set_ex(1, 32'h0000_0101, 32'h0, 5'd11, 1, 0, 1, 1, 2'b10, 0);
`ifdef MEM_MISALIGN_TRAP_EN
      #1;
      check("mis_no_stall", {31'd0, stall_out}, 32'd0);
      tick();
      check("mis_no_req", {31'd0, dmem_if.req}, 32'd0);
      check("mis_wb_valid", {31'd0, wb_valid}, 32'd1);
      check("mis_regwrite", {31'd0, wb_RegWrite}, 32'd0);
      check("mis_flag", {31'd0, misalign}, 32'd1);
      ex_valid = 1'b0;
      tick();
      check("mis_flag_clear", {31'd0, misalign}, 32'd0);
`else
      run_mem(0, 32'hCAFE_F00D, stalls);
      check("mis_addr", seen_addr, 32'h0000_0100);
      check("mis_data", wb_mem_data, 32'hCAFE_F00D);
      check("mis_regwrite", {31'd0, wb_RegWrite}, 32'd1);
      ex_valid = 1'b0;
      tick();
`endif

      // Reset in the middle of an ACCESS.
      set_ex(1, 32'h0000_0500, 32'h0, 5'd12, 1, 0, 1, 1, 2'b10, 0);
      tick();
      check("rst_mid_req_before", {31'd0, dmem_if.req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_req", {31'd0, dmem_if.req}, 32'd0);
      check("rst_mid_stall", {31'd0, stall_out}, 32'd0);
      check("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
      ex_valid = 1'b0;
      tick();
      rst_n       = 1'b1;
      dmem_if.ack = 1'b1;
      dmem_if.rdata = 32'h1111_2222;
      tick();
      dmem_if.ack = 1'b0;
      check("rst_late_ack", {31'd0, wb_valid}, 32'd0);
      check("rst_late_req", {31'd0, dmem_if.req}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
